branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Branch-direction controller for the pipelined core. It keeps a 2-bit saturating branch history table (BHT) and predicts conditional branches in ID. It tracks each prediction into EX and compares it against the branch-condition unit's resolved `en_jump`. On a disagreement it issues the PC redirect and the pipeline flushes. It sits between decode, the branch-condition unit and the fetch PC mux.

## Interface
Parameters:
- `n`, 32, address/data width
- `IDX_W`, 6, BHT index width (2^IDX_W entries)
- `CNT_W`, 16, mispredict counter width

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; synchronous, active-high
- `stall_i`  in  1  ID hold (load-use); ID is frozen, EX receives a bubble
- `id_valid_i`  in  1  ID slot holds a valid instruction
- `id_is_branch_i`  in  1  ID instruction is a conditional branch
- `id_pc_i`  in  n  PC of ID instruction
- `id_target_i`  in  n  branch target computed in ID
- `ex_en_jump_i`  in  1  resolved branch outcome for the instruction in EX
- `redirect_o`  out  1  load `redirect_pc_o` into fetch PC
- `redirect_pc_o`  out  n  redirect address
- `flush_if_o`  out  1  squash IF/ID register
- `flush_id_o`  out  1  squash ID/EX register
- `pred_taken_o`  out  1  prediction for current ID branch (debug)
- `mispred_cnt_o`  out  CNT_W  saturating mispredict count

## Operation
- BHT entry encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction is the MSB.
- Index is `pc[IDX_W+1:2]`.
- ID predict:
  - `pred_taken_o = id_valid_i & id_is_branch_i & BHT[idx(id_pc_i)][1]`.
- ID redirect:
  - Condition: `pred_taken_o & ~stall_i` and no EX mispredict this cycle.
  - Action: `redirect_o=1`, `redirect_pc_o=id_target_i`, `flush_if_o=1`.
  - The ID branch itself continues to EX.
- EX tracking register (`ex_vld`, `ex_pred`, `ex_pc`, `ex_tgt`), updated every cycle:
  - `flush_id_o` or `stall_i` → bubble (`ex_vld=0`).
  - Otherwise it captures the ID branch fields, with `ex_vld = id_valid_i & id_is_branch_i`.
- EX resolve, when `ex_vld`:
  - Mispredict when `ex_en_jump_i != ex_pred`.
  - Actual taken → `redirect_pc_o=ex_tgt`.
  - Actual not taken → `redirect_pc_o=ex_pc+4`.
  - Either case asserts `redirect_o`, `flush_if_o` and `flush_id_o`.
- EX mispredict has priority over the ID redirect. `stall_i` does not suppress EX resolution.
- BHT update: on every `ex_vld` edge, `BHT[idx(ex_pc)]` increments if `ex_en_jump_i`, else decrements. Saturates at 11/00.
- Mispredict counter: `mispred_cnt_o` increments on each EX mispredict and saturates at all-ones.
- Read-during-write on the same index: ID reads the old value; there is no bypass.
- `redirect_pc_o` is 0 when `redirect_o=0`.

## Timing
- ID predict and redirect: combinational, same cycle as the ID inputs.
- EX redirect: combinational from `ex_en_jump_i`, same cycle.
- BHT and counter update: at the rising edge ending the EX cycle.
- Penalties: correctly predicted taken = 1 bubble; mispredict = 2 bubbles; predicted and resolved not-taken = 0 bubbles.
- Reset, which also applies mid-operation, on the next edge:
  - all BHT entries become 01;
  - `ex_vld=0`;
  - `mispred_cnt_o=0`.
- While `rst_i` is high, all outputs are forced to 0.

## Structure
- Package `bp_pkg`:
  - `bht_cnt_t` enum (SNT/WNT/WT/ST);
  - `BHT_RESET = WNT`;
  - function `bht_next(cnt, taken)`.
- Sub-module `bht`: `2^IDX_W × 2` register array with one combinational read port and one synchronous saturating update port with reset.
- Top level contains the EX tracking register, the redirect/flush priority logic and the mispredict counter.

## Test plan
- **Reset, first taken.** After reset, branch pc=0x40, target 0x80 in ID.
  - ID: `pred_taken_o=0`, no redirect.
  - Next cycle EX, `ex_en_jump_i=1`: `redirect_o=1`, `redirect_pc_o=0x80`, both flushes set; BHT[16] becomes 10; count=1.
- **Learned taken.** Same branch again.
  - ID: redirect to 0x80, `flush_if_o` only.
  - EX `en_jump=1`: no redirect; BHT[16] becomes 11.
  - Five more taken: BHT[16] stays 11, count stays 1.
- **Taken-predicted, not taken.** Predicted taken, EX `en_jump=0`.
  - `redirect_pc_o=0x44`, both flushes; BHT[16] 11→10; count increments.
- **Simultaneous redirects.** Same cycle: EX mispredict plus an ID branch predicted taken at 0x100.
  - EX redirect address wins.
  - Next cycle `ex_vld=0`; BHT for 0x100 is unchanged.
- **Stall.** `stall_i=1` for 2 cycles with a predicted-taken ID branch.
  - No redirect and EX receives bubbles while stalled.
  - The cycle after release: redirect to target.
- **Reset mid-operation.** Assert `rst_i` with BHT trained and count=5.
  - Next cycle: all predictions NT, count=0, all outputs 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch-direction predictor: 2-bit saturating counter
// encoding, its reset value and the saturating next-state function.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_cnt_t;

   localparam bht_cnt_t BHT_RESET = WNT;

   function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
      bht_cnt_t nxt;
      nxt = cnt;
      unique case (cnt)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = BHT_RESET;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predict_ctrl_bht.sv
// Branch history table: 2^IDX_W two-bit counters, combinational read, saturating
// update at the clock edge; no read/write bypass, so a same-index read sees the old value.
module bht
   import bp_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int DEPTH = 1 << IDX_W;

   bht_cnt_t mem [DEPTH];

   assign rd_cnt = mem[rd_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= BHT_RESET;
         end
      end else if (upd_en) begin
         mem[upd_idx] <= bht_next(mem[upd_idx], upd_taken);
      end
   end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch-direction controller: predicts in ID, resolves in EX, drives fetch redirect and flushes.
// Redirects are combinational in the same cycle; EX mispredict overrides the ID redirect and ignores stall.
module branch_predict_ctrl
   import bp_pkg::*;
#(
   parameter int n     = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             id_valid_i,
   input  logic             id_is_branch_i,
   input  logic [n-1:0]     id_pc_i,
   input  logic [n-1:0]     id_target_i,
   input  logic             ex_en_jump_i,
   output logic             redirect_o,
   output logic [n-1:0]     redirect_pc_o,
   output logic             flush_if_o,
   output logic             flush_id_o,
   output logic             pred_taken_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam logic [n-1:0]     PC_STEP = n'(4);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             ex_vld;
   logic             ex_pred;
   logic [n-1:0]     ex_pc;
   logic [n-1:0]     ex_tgt;
   logic [CNT_W-1:0] mispred_cnt;

   logic [1:0]       id_cnt;
   logic             id_pred;
   logic             id_redirect;
   logic             ex_mispred;
   logic             redirect;
   logic [n-1:0]     redirect_pc;

   bht #(
      .IDX_W (IDX_W)
   ) u_bht (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_idx    (id_pc_i[IDX_W+1:2]),
      .rd_cnt    (id_cnt),
      .upd_en    (ex_vld),
      .upd_idx   (ex_pc[IDX_W+1:2]),
      .upd_taken (ex_en_jump_i)
   );

   always_comb begin
      id_pred     = id_valid_i & id_is_branch_i & id_cnt[1];
      ex_mispred  = ex_vld & (ex_en_jump_i != ex_pred);
      id_redirect = id_pred & ~stall_i & ~ex_mispred;
      redirect    = ex_mispred | id_redirect;
      redirect_pc = '0;
      if (ex_mispred) begin
         redirect_pc = ex_en_jump_i ? ex_tgt : (ex_pc + PC_STEP);
      end else if (id_redirect) begin
         redirect_pc = id_target_i;
      end
   end

   // Outputs are held quiet for the whole reset interval, not just after the edge.
   always_comb begin
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      flush_if_o    = 1'b0;
      flush_id_o    = 1'b0;
      pred_taken_o  = 1'b0;
      mispred_cnt_o = '0;
      if (!rst_i) begin
         redirect_o    = redirect;
         redirect_pc_o = redirect_pc;
         flush_if_o    = redirect;
         flush_id_o    = ex_mispred;
         pred_taken_o  = id_pred;
         mispred_cnt_o = mispred_cnt;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_vld  <= 1'b0;
         ex_pred <= 1'b0;
         ex_pc   <= '0;
         ex_tgt  <= '0;
      end else if (ex_mispred || stall_i) begin
         ex_vld  <= 1'b0;
      end else begin
         ex_vld  <= id_valid_i & id_is_branch_i;
         ex_pred <= id_pred;
         ex_pc   <= id_pc_i;
         ex_tgt  <= id_target_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mispred_cnt <= '0;
      end else if (ex_mispred && (mispred_cnt != '1)) begin
         mispred_cnt <= mispred_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: drives at negedge, checks combinational outputs 1ns later.
module tb_branch_predict_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        stall_i;
   logic        id_valid_i;
   logic        id_is_branch_i;
   logic [31:0] id_pc_i;
   logic [31:0] id_target_i;
   logic        ex_en_jump_i;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        flush_if_o;
   logic        flush_id_o;
   logic        pred_taken_o;
   logic [15:0] mispred_cnt_o;

   int vec = 0;
   int err = 0;

   always #5 clk_i = ~clk_i;

   branch_predict_ctrl #(.n(32), .IDX_W(6), .CNT_W(16)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .stall_i        (stall_i),
      .id_valid_i     (id_valid_i),
      .id_is_branch_i (id_is_branch_i),
      .id_pc_i        (id_pc_i),
      .id_target_i    (id_target_i),
      .ex_en_jump_i   (ex_en_jump_i),
      .redirect_o     (redirect_o),
      .redirect_pc_o  (redirect_pc_o),
      .flush_if_o     (flush_if_o),
      .flush_id_o     (flush_id_o),
      .pred_taken_o   (pred_taken_o),
      .mispred_cnt_o  (mispred_cnt_o)
   );

   // One cycle of stimulus; returns 1ns after the negedge so outputs have settled.
   task automatic drive(input logic rst, input logic br, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic jump, input logic stall);
      @(negedge clk_i);
      rst_i          = rst;
      id_valid_i     = br;
      id_is_branch_i = br;
      id_pc_i        = pc;
      id_target_i    = tgt;
      ex_en_jump_i   = jump;
      stall_i        = stall;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b1, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o, pred_taken_o} !== 4'b0000) begin
         err++; $display("FAIL reset_ctl got %b exp 0000", {redirect_o, flush_if_o, flush_id_o, pred_taken_o});
      end
      vec++;
      if (redirect_pc_o !== 32'h0 || mispred_cnt_o !== 16'h0) begin
         err++; $display("FAIL reset_data pc=%h cnt=%0d exp 0/0", redirect_pc_o, mispred_cnt_o);
      end
   endtask

   task automatic test_first_taken();
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b0 || redirect_o !== 1'b0) begin
         err++; $display("FAIL first_id pred=%b redir=%b exp 0/0", pred_taken_o, redirect_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o} !== 3'b111 || redirect_pc_o !== 32'h80) begin
         err++; $display("FAIL first_ex got %b pc=%h exp 111 pc=80", {redirect_o, flush_if_o, flush_id_o}, redirect_pc_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      vec++;
      if (mispred_cnt_o !== 16'd1 || redirect_o !== 1'b0) begin
         err++; $display("FAIL first_cnt cnt=%0d redir=%b exp 1/0", mispred_cnt_o, redirect_o);
      end
   endtask

   task automatic test_learned_taken();
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
         vec++;
         if ({redirect_o, flush_if_o, flush_id_o, pred_taken_o} !== 4'b1101 || redirect_pc_o !== 32'h80) begin
            err++; $display("FAIL learned_id[%0d] got %b pc=%h exp 1101 pc=80", k,
                            {redirect_o, flush_if_o, flush_id_o, pred_taken_o}, redirect_pc_o);
         end
         drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         vec++;
         if (redirect_o !== 1'b0 || flush_id_o !== 1'b0) begin
            err++; $display("FAIL learned_ex[%0d] redir=%b flush_id=%b exp 0/0", k, redirect_o, flush_id_o);
         end
      end
      vec++;
      if (mispred_cnt_o !== 16'd1) begin
         err++; $display("FAIL learned_cnt got %0d exp 1", mispred_cnt_o);
      end
   endtask

   task automatic test_taken_not_taken();
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o} !== 3'b111 || redirect_pc_o !== 32'h44) begin
         err++; $display("FAIL tnt_ex got %b pc=%h exp 111 pc=44", {redirect_o, flush_if_o, flush_id_o}, redirect_pc_o);
      end
      // BHT[16] now weak-taken: still predicts taken; retrain to strong.
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b1 || mispred_cnt_o !== 16'd2) begin
         err++; $display("FAIL tnt_after pred=%b cnt=%0d exp 1/2", pred_taken_o, mispred_cnt_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_simultaneous();
      // Train 0x100 (index 0) to weak-taken with one mispredicted taken.
      drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      vec++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
         err++; $display("FAIL sim_train redir=%b pc=%h exp 1/200", redirect_o, redirect_pc_o);
      end
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o, pred_taken_o} !== 4'b1111 || redirect_pc_o !== 32'h44) begin
         err++; $display("FAIL sim_prio got %b pc=%h exp 1111 pc=44",
                         {redirect_o, flush_if_o, flush_id_o, pred_taken_o}, redirect_pc_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      vec++;
      if (redirect_o !== 1'b0 || mispred_cnt_o !== 16'd4) begin
         err++; $display("FAIL sim_bubble redir=%b cnt=%0d exp 0/4", redirect_o, mispred_cnt_o);
      end
      drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b1 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
         err++; $display("FAIL sim_unchanged pred=%b redir=%b pc=%h exp 1/1/200", pred_taken_o, redirect_o, redirect_pc_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_stall();
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b1);
         vec++;
         if (redirect_o !== 1'b0 || flush_if_o !== 1'b0 || pred_taken_o !== 1'b1) begin
            err++; $display("FAIL stall[%0d] redir=%b flush_if=%b pred=%b exp 0/0/1", k, redirect_o, flush_if_o, pred_taken_o);
         end
      end
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o} !== 3'b110 || redirect_pc_o !== 32'h80) begin
         err++; $display("FAIL stall_release got %b pc=%h exp 110 pc=80", {redirect_o, flush_if_o, flush_id_o}, redirect_pc_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      vec++;
      if (redirect_o !== 1'b0 || mispred_cnt_o !== 16'd4) begin
         err++; $display("FAIL stall_resolve redir=%b cnt=%0d exp 0/4", redirect_o, mispred_cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if (mispred_cnt_o !== 16'd5 || pred_taken_o !== 1'b1) begin
         err++; $display("FAIL mid_pre cnt=%0d pred=%b exp 5/1", mispred_cnt_o, pred_taken_o);
      end
      drive(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if ({redirect_o, flush_if_o, flush_id_o, pred_taken_o} !== 4'b0000 || mispred_cnt_o !== 16'd0) begin
         err++; $display("FAIL mid_rst got %b cnt=%0d exp 0000/0",
                         {redirect_o, flush_if_o, flush_id_o, pred_taken_o}, mispred_cnt_o);
      end
      drive(1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b0 || redirect_o !== 1'b0 || mispred_cnt_o !== 16'd0) begin
         err++; $display("FAIL mid_after40 pred=%b redir=%b cnt=%0d exp 0/0/0", pred_taken_o, redirect_o, mispred_cnt_o);
      end
      drive(1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b0 || redirect_o !== 1'b0) begin
         err++; $display("FAIL mid_after100 pred=%b redir=%b exp 0/0", pred_taken_o, redirect_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_low_saturation();
      // Index 32: 01 -> 00 -> 00, then one taken -> 01 must still predict not-taken.
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 32'h80, 32'h300, 1'b0, 1'b0);
         drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         vec++;
         if (redirect_o !== 1'b0) begin
            err++; $display("FAIL sat_nt[%0d] redir=%b exp 0", k, redirect_o);
         end
      end
      drive(1'b0, 1'b1, 32'h80, 32'h300, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b0) begin
         err++; $display("FAIL sat_floor pred=%b exp 0", pred_taken_o);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      vec++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h300) begin
         err++; $display("FAIL sat_mis redir=%b pc=%h exp 1/300", redirect_o, redirect_pc_o);
      end
      drive(1'b0, 1'b1, 32'h80, 32'h300, 1'b0, 1'b0);
      vec++;
      if (pred_taken_o !== 1'b0 || mispred_cnt_o !== 16'd1) begin
         err++; $display("FAIL sat_recover pred=%b cnt=%0d exp 0/1", pred_taken_o, mispred_cnt_o);
      end
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; id_valid_i = 1'b0; id_is_branch_i = 1'b0;
      id_pc_i = '0; id_target_i = '0; ex_en_jump_i = 1'b0;
      test_reset();
      test_first_taken();
      test_learned_taken();
      test_taken_not_taken();
      test_simultaneous();
      test_stall();
      test_reset_mid();
      test_low_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
